// File: rtl/bcd_field_counter_rpt_if.sv
// Bus bundle for one BCD date/time setting field counter.
//   master : drives field select, buttons, load and runtime limit; sees count/digits/pulses
//   slave  : the counter itself
interface bcd_field_counter_rpt_if #(
    parameter int unsigned W = 7
);
    logic [3:0]   field_sel;
    logic         en_up;
    logic         en_down;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] max_dyn;
    logic [W-1:0] count;
    logic [3:0]   digit1;
    logic [3:0]   digit0;
    logic         carry;
    logic         borrow;

    modport master (
        output field_sel, en_up, en_down, load, load_val, max_dyn,
        input  count, digit1, digit0, carry, borrow
    );

    modport slave (
        input  field_sel, en_up, en_down, load, load_val, max_dyn,
        output count, digit1, digit0, carry, borrow
    );
endinterface

// File: rtl/bcd_field_counter_rpt.sv
// 2-digit BCD up/down counter for one RTC setting field with button edge detection,
// press-and-hold auto-repeat, runtime upper limit, parallel load and carry/borrow pulses.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    slave side of bcd_field_counter_rpt_if:
//          in  field_sel, en_up, en_down, load, load_val, max_dyn
//          out count (binary), digit1/digit0 (BCD tens/units, combinational), carry, borrow
module bcd_field_counter_rpt #(
    parameter int unsigned FIELD_ID      = 5,
    parameter int unsigned MIN_VAL       = 1,
    parameter int unsigned MAX_VAL       = 12,
    parameter int unsigned W             = 7,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    bcd_field_counter_rpt_if.slave  bus
);
    localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          held_up_q, held_up_d;
    logic          up_rel_q, dn_rel_q;
    logic [W-1:0]  count_q, count_d;
    logic          carry_q, carry_d;
    logic          borrow_q, borrow_d;

    logic          active;
    logic          dir_up, dir_dn;
    logic          up_edge, dn_edge;
    logic          still_held;
    logic          step_c, step_up_c;
    logic [W-1:0]  limit;

    assign active  = (bus.field_sel == 4'(FIELD_ID));
    assign dir_up  = bus.en_up & ~bus.en_down;
    assign dir_dn  = bus.en_down & ~bus.en_up;
    // Edge only after the button has been seen released at least once since reset,
    // so a button held through reset does not step.
    assign up_edge = bus.en_up & up_rel_q;
    assign dn_edge = bus.en_down & dn_rel_q;
    assign still_held = active & (held_up_q ? dir_up : dir_dn);

    // Runtime limit, never above the static maximum.
    always_comb begin
        limit = W'(MAX_VAL);
        if (bus.max_dyn != '0 && bus.max_dyn < W'(MAX_VAL)) begin
            limit = bus.max_dyn;
        end
    end

    // State register and button/release tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            held_up_q <= 1'b0;
            up_rel_q  <= 1'b0;
            dn_rel_q  <= 1'b0;
            count_q   <= W'(MIN_VAL);
            carry_q   <= 1'b0;
            borrow_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            held_up_q <= held_up_d;
            up_rel_q  <= ~bus.en_up;
            dn_rel_q  <= ~bus.en_down;
            count_q   <= count_d;
            carry_q   <= carry_d;
            borrow_q  <= borrow_d;
        end
    end

    // Press / hold / repeat sequencing.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        held_up_d = held_up_q;
        step_c    = 1'b0;
        step_up_c = held_up_q;
        case (state_q)
            IDLE: begin
                timer_d   = '0;
                step_up_c = dir_up;
                if (active && ((dir_up && up_edge) || (dir_dn && dn_edge))) begin
                    step_c    = 1'b1;
                    held_up_d = dir_up;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (!still_held) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == TW'(REPEAT_DELAY - 1)) begin
                    step_c  = 1'b1;
                    state_d = REPEAT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            REPEAT: begin
                if (!still_held) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == TW'(REPEAT_PERIOD - 1)) begin
                    step_c  = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Count update: load beats clamp beats step.
    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (bus.load) begin
            if (bus.load_val >= W'(MIN_VAL) && bus.load_val <= limit) begin
                count_d = bus.load_val;
            end
        end else if (count_q > limit) begin
            count_d = limit;
        end else if (step_c) begin
            if (step_up_c) begin
                if (count_q >= limit) begin
                    count_d = W'(MIN_VAL);
                    carry_d = 1'b1;
                end else begin
                    count_d = count_q + W'(1);
                end
            end else begin
                if (count_q <= W'(MIN_VAL)) begin
                    count_d  = limit;
                    borrow_d = 1'b1;
                end else begin
                    count_d = count_q - W'(1);
                end
            end
        end
    end

    assign bus.count  = count_q;
    assign bus.carry  = carry_q;
    assign bus.borrow = borrow_q;
    assign bus.digit1 = 4'(count_q / W'(10));
    assign bus.digit0 = 4'(count_q % W'(10));
endmodule

// File: tb/tb_bcd_field_counter_rpt.sv
module tb_bcd_field_counter_rpt;
    localparam int unsigned W = 7;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    bcd_field_counter_rpt_if #(.W(W)) bus ();

    bcd_field_counter_rpt #(
        .FIELD_ID(5), .MIN_VAL(1), .MAX_VAL(12), .W(W),
        .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_load(input int v);
        bus.load_val = W'(v);
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.field_sel = 4'd5;
        bus.en_up = 1'b0; bus.en_down = 1'b0;
        bus.load = 1'b0; bus.load_val = '0; bus.max_dyn = '0;
        tick(); tick();
        n_tests++;
        if (bus.count !== 7'd1 || bus.carry !== 1'b0 || bus.borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d carry=%b borrow=%b, want 1 0 0", bus.count, bus.carry, bus.borrow);
        end
        n_tests++;
        if (bus.digit1 !== 4'd0 || bus.digit0 !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_digits: %0d/%0d, want 0/1", bus.digit1, bus.digit0);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_step_up();
        for (int i = 0; i < 3; i++) begin
            bus.en_up = 1'b1;
            tick();
            n_tests++;
            if (bus.count !== 7'(2 + i) || bus.carry !== 1'b0) begin
                n_fail++;
                $display("FAIL step_up[%0d]: count=%0d carry=%b, want %0d 0", i, bus.count, bus.carry, 2 + i);
            end
            bus.en_up = 1'b0;
            tick();
        end
        n_tests++;
        if (bus.digit1 !== 4'd0 || bus.digit0 !== 4'd4) begin
            n_fail++;
            $display("FAIL step_up_digits: %0d/%0d, want 0/4", bus.digit1, bus.digit0);
        end
    endtask

    task automatic test_wrap();
        do_load(12);
        n_tests++;
        if (bus.count !== 7'd12) begin
            n_fail++;
            $display("FAIL wrap_load: count=%0d, want 12", bus.count);
        end
        bus.en_up = 1'b1;
        tick();
        n_tests++;
        if (bus.count !== 7'd1 || bus.carry !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_up: count=%0d carry=%b, want 1 1", bus.count, bus.carry);
        end
        bus.en_up = 1'b0;
        tick();
        n_tests++;
        if (bus.carry !== 1'b0 || bus.count !== 7'd1) begin
            n_fail++;
            $display("FAIL carry_pulse: carry=%b count=%0d, want 0 1", bus.carry, bus.count);
        end
        bus.en_down = 1'b1;
        tick();
        n_tests++;
        if (bus.count !== 7'd12 || bus.borrow !== 1'b1 || bus.digit1 !== 4'd1 || bus.digit0 !== 4'd2) begin
            n_fail++;
            $display("FAIL wrap_down: count=%0d borrow=%b digits=%0d/%0d, want 12 1 1/2",
                     bus.count, bus.borrow, bus.digit1, bus.digit0);
        end
        bus.en_down = 1'b0;
        tick();
        n_tests++;
        if (bus.borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL borrow_pulse: borrow=%b, want 0", bus.borrow);
        end
    endtask

    task automatic test_hold();
        int exp_cnt [12] = '{2, 2, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6};
        do_load(1);
        bus.en_up = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_tests++;
            if (bus.count !== 7'(exp_cnt[c])) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: count=%0d, want %0d", c + 1, bus.count, exp_cnt[c]);
            end
        end
        bus.en_up = 1'b0;
        tick(); tick(); tick();
        n_tests++;
        if (bus.count !== 7'd6) begin
            n_fail++;
            $display("FAIL hold_release: count=%0d, want 6", bus.count);
        end
    endtask

    task automatic test_clamp();
        bus.max_dyn = '0;
        do_load(11);
        bus.max_dyn = 7'd9;
        tick();
        n_tests++;
        if (bus.count !== 7'd9 || bus.carry !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp: count=%0d carry=%b, want 9 0", bus.count, bus.carry);
        end
        bus.en_up = 1'b1;
        tick();
        n_tests++;
        if (bus.count !== 7'd1 || bus.carry !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_wrap: count=%0d carry=%b, want 1 1", bus.count, bus.carry);
        end
        bus.en_up = 1'b0;
        bus.max_dyn = '0;
        tick();
    endtask

    task automatic test_ignore();
        bus.en_up = 1'b1; bus.en_down = 1'b1;
        tick(); tick();
        n_tests++;
        if (bus.count !== 7'd1) begin
            n_fail++;
            $display("FAIL both_buttons: count=%0d, want 1", bus.count);
        end
        bus.en_up = 1'b0; bus.en_down = 1'b0;
        tick();
        bus.field_sel = 4'd3;
        bus.en_up = 1'b1;
        tick(); tick();
        n_tests++;
        if (bus.count !== 7'd1) begin
            n_fail++;
            $display("FAIL other_field: count=%0d, want 1", bus.count);
        end
        bus.en_up = 1'b0;
        bus.field_sel = 4'd5;
        tick();
        do_load(13);
        n_tests++;
        if (bus.count !== 7'd1) begin
            n_fail++;
            $display("FAIL load_out_of_range: count=%0d, want 1", bus.count);
        end
        bus.load_val = 7'd7;
        bus.load = 1'b1;
        bus.en_up = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.en_up = 1'b0;
        n_tests++;
        if (bus.count !== 7'd7) begin
            n_fail++;
            $display("FAIL load_over_step: count=%0d, want 7", bus.count);
        end
        tick();
        n_tests++;
        if (bus.count !== 7'd7) begin
            n_fail++;
            $display("FAIL load_then_release: count=%0d, want 7", bus.count);
        end
    endtask

    task automatic test_reset_repeat();
        do_load(5);
        bus.en_up = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        n_tests++;
        if (bus.count !== 7'd7) begin
            n_fail++;
            $display("FAIL pre_reset_repeat: count=%0d, want 7", bus.count);
        end
        #1 reset = 1'b1;
        #1;
        n_tests++;
        if (bus.count !== 7'd1 || bus.carry !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: count=%0d carry=%b, want 1 0", bus.count, bus.carry);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        n_tests++;
        if (bus.count !== 7'd1) begin
            n_fail++;
            $display("FAIL held_after_reset: count=%0d, want 1", bus.count);
        end
        bus.en_up = 1'b0;
        tick();
        bus.en_up = 1'b1;
        tick();
        n_tests++;
        if (bus.count !== 7'd2) begin
            n_fail++;
            $display("FAIL repress_after_reset: count=%0d, want 2", bus.count);
        end
        bus.en_up = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_step_up();
        test_wrap();
        test_hold();
        test_clamp();
        test_ignore();
        test_reset_repeat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
